// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/freeze control
// and a saturating count of inserted load-use bubbles.
module id_ex_hazard_reg #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_REG      = 32,
  parameter int NB_OPCODE   = 6,
  parameter int NB_CNT      = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_freeze,
  input  logic                   i_flush,
  input  logic                   i_cnt_clear,
  input  logic                   i_valid_id,
  input  logic [NB_REG_ADDR-1:0] i_rs_id,
  input  logic [NB_REG_ADDR-1:0] i_rt_id,
  input  logic                   i_use_rt_id,
  input  logic [NB_REG_ADDR-1:0] i_rd_id,
  input  logic                   i_we_id,
  input  logic                   i_mem_read_id,
  input  logic [NB_OPCODE-1:0]   i_opcode_id,
  input  logic [NB_REG-1:0]      i_data_a_id,
  input  logic [NB_REG-1:0]      i_data_b_id,
  input  logic [NB_REG-1:0]      i_imm_id,
  output logic                   o_stall,
  output logic                   o_valid_ex,
  output logic [NB_REG_ADDR-1:0] o_rs_ex,
  output logic [NB_REG_ADDR-1:0] o_rt_ex,
  output logic [NB_REG_ADDR-1:0] o_rd_ex,
  output logic                   o_we_ex,
  output logic                   o_mem_read_ex,
  output logic [NB_OPCODE-1:0]   o_opcode_ex,
  output logic [NB_REG-1:0]      o_data_a_ex,
  output logic [NB_REG-1:0]      o_data_b_ex,
  output logic [NB_REG-1:0]      o_imm_ex,
  output logic [NB_CNT-1:0]      o_bubble_cnt
);

  logic hazard;
  logic rs_match;
  logic rt_match;
  logic load_bubble;

  assign rs_match    = (i_rs_id == o_rd_ex);
  assign rt_match    = i_use_rt_id && (i_rt_id == o_rd_ex);
  assign hazard      = o_valid_ex && o_mem_read_ex && o_we_ex && i_valid_id &&
                       (o_rd_ex != '0) && (rs_match || rt_match);
  // A squashed ID instruction must not hold the front end.
  assign o_stall     = hazard && !i_flush;
  assign load_bubble = i_flush || hazard;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid_ex    <= 1'b0;
      o_rs_ex       <= '0;
      o_rt_ex       <= '0;
      o_rd_ex       <= '0;
      o_we_ex       <= 1'b0;
      o_mem_read_ex <= 1'b0;
      o_opcode_ex   <= '0;
      o_data_a_ex   <= '0;
      o_data_b_ex   <= '0;
      o_imm_ex      <= '0;
    end else if (!i_freeze) begin
      if (load_bubble) begin
        o_valid_ex    <= 1'b0;
        o_rs_ex       <= '0;
        o_rt_ex       <= '0;
        o_rd_ex       <= '0;
        o_we_ex       <= 1'b0;
        o_mem_read_ex <= 1'b0;
        o_opcode_ex   <= '0;
        o_data_a_ex   <= '0;
        o_data_b_ex   <= '0;
        o_imm_ex      <= '0;
      end else begin
        o_valid_ex    <= i_valid_id;
        o_rs_ex       <= i_rs_id;
        o_rt_ex       <= i_rt_id;
        o_rd_ex       <= i_rd_id;
        // Writes to $0 are dropped here so forwarding never sees them.
        o_we_ex       <= i_we_id && i_valid_id && (i_rd_id != '0);
        o_mem_read_ex <= i_mem_read_id;
        o_opcode_ex   <= i_opcode_id;
        o_data_a_ex   <= i_data_a_id;
        o_data_b_ex   <= i_data_b_id;
        o_imm_ex      <= i_imm_id;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_bubble_cnt <= '0;
    end else if (!i_freeze) begin
      if (i_cnt_clear) begin
        o_bubble_cnt <= '0;
      end else if (!i_flush && hazard && (o_bubble_cnt != '1)) begin
        o_bubble_cnt <= o_bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: reference model of the EX stage compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_id_ex_hazard_reg;

  localparam int NA = 5;
  localparam int NR = 32;
  localparam int NO = 6;
  localparam int NC = 2;
  localparam int CNT_MAX = (1 << NC) - 1;

  logic          clk, rst_n;
  logic          freeze, flush, cnt_clear;
  logic          valid_id, use_rt_id, we_id, mem_read_id;
  logic [NA-1:0] rs_id, rt_id, rd_id;
  logic [NO-1:0] opcode_id;
  logic [NR-1:0] data_a_id, data_b_id, imm_id;
  logic          stall, valid_ex, we_ex, mem_read_ex;
  logic [NA-1:0] rs_ex, rt_ex, rd_ex;
  logic [NO-1:0] opcode_ex;
  logic [NR-1:0] data_a_ex, data_b_ex, imm_ex;
  logic [NC-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_hazard_reg #(.NB_REG_ADDR(NA), .NB_REG(NR), .NB_OPCODE(NO), .NB_CNT(NC)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_freeze(freeze), .i_flush(flush),
    .i_cnt_clear(cnt_clear), .i_valid_id(valid_id), .i_rs_id(rs_id), .i_rt_id(rt_id),
    .i_use_rt_id(use_rt_id), .i_rd_id(rd_id), .i_we_id(we_id), .i_mem_read_id(mem_read_id),
    .i_opcode_id(opcode_id), .i_data_a_id(data_a_id), .i_data_b_id(data_b_id),
    .i_imm_id(imm_id), .o_stall(stall), .o_valid_ex(valid_ex), .o_rs_ex(rs_ex),
    .o_rt_ex(rt_ex), .o_rd_ex(rd_ex), .o_we_ex(we_ex), .o_mem_read_ex(mem_read_ex),
    .o_opcode_ex(opcode_ex), .o_data_a_ex(data_a_ex), .o_data_b_ex(data_b_ex),
    .o_imm_ex(imm_ex), .o_bubble_cnt(bubble_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit            valid, we, mr;
    logic [NA-1:0] rs, rt, rd;
    logic [NO-1:0] op;
    logic [NR-1:0] a, b, imm;
  } ex_t;

  ex_t m_ex;
  int  m_cnt;

  function automatic ex_t bubble();
    ex_t e;
    e.valid = 0; e.we = 0; e.mr = 0;
    e.rs = '0; e.rt = '0; e.rd = '0; e.op = '0; e.a = '0; e.b = '0; e.imm = '0;
    return e;
  endfunction

  // A load in EX whose result ID wants right now.
  function automatic bit m_hazard();
    bit uses;
    uses = (int'(rs_id) == int'(m_ex.rd)) || (use_rt_id && int'(rt_id) == int'(m_ex.rd));
    return m_ex.valid && m_ex.mr && m_ex.we && valid_id && (m_ex.rd != 0) && uses;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex  = bubble();
      m_cnt = 0;
    end else if (!freeze) begin
      bit hz;
      hz = m_hazard();
      if (cnt_clear) m_cnt = 0;
      else if (hz && !flush) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (flush || hz) m_ex = bubble();
      else begin
        m_ex.valid = valid_id; m_ex.mr = mem_read_id;
        m_ex.we = we_id && valid_id && (rd_id != 0);
        m_ex.rs = rs_id; m_ex.rt = rt_id; m_ex.rd = rd_id; m_ex.op = opcode_id;
        m_ex.a = data_a_id; m_ex.b = data_b_id; m_ex.imm = imm_id;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [NR-1:0] act, input logic [NR-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge: whole EX stage against the model.
  always @(negedge clk) begin
    check("m_stall", 32'(stall), 32'(m_hazard() && !flush));
    check("m_valid", 32'(valid_ex), 32'(m_ex.valid));
    check("m_we", 32'(we_ex), 32'(m_ex.we));
    check("m_mr", 32'(mem_read_ex), 32'(m_ex.mr));
    check("m_rs", 32'(rs_ex), 32'(m_ex.rs));
    check("m_rt", 32'(rt_ex), 32'(m_ex.rt));
    check("m_rd", 32'(rd_ex), 32'(m_ex.rd));
    check("m_op", 32'(opcode_ex), 32'(m_ex.op));
    check("m_a", data_a_ex, m_ex.a);
    check("m_b", data_b_ex, m_ex.b);
    check("m_imm", imm_ex, m_ex.imm);
    check("m_cnt", 32'(bubble_cnt), 32'(m_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input bit urt, input int rd,
                        input bit we, input bit mr, input int op);
    valid_id = v; rs_id = NA'(rs); rt_id = NA'(rt); use_rt_id = urt; rd_id = NA'(rd);
    we_id = we; mem_read_id = mr; opcode_id = NO'(op);
    data_a_id = 32'hA000_0000 + 32'(rs); data_b_id = 32'hB000_0000 + 32'(rt);
    imm_id = 32'h0000_1000 + 32'(op);
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_id();
    valid_id = 1'($urandom_range(0, 1)); rs_id = NA'($urandom_range(0, 31));
    rt_id = NA'($urandom_range(0, 31)); use_rt_id = 1'($urandom_range(0, 1));
    rd_id = NA'($urandom_range(0, 31)); we_id = 1'($urandom_range(0, 1));
    mem_read_id = 1'($urandom_range(0, 1)); opcode_id = NO'($urandom_range(0, 63));
    data_a_id = $urandom; data_b_id = $urandom; imm_id = $urandom;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 0; freeze = 0; flush = 0; cnt_clear = 0;
    for (int i = 0; i < 3; i++) begin
      random_id();
      step();
    end
    check("rst_valid", 32'(valid_ex), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_data_a", data_a_ex, 0);
    check("rst_cnt", 32'(bubble_cnt), 0);
    set_nop();
    rst_n = 1;
    step();

    // ADD rs=2 rt=3 rd=4
    set_id(1, 2, 3, 1, 4, 1, 0, 6'h20);
    step();
    check("pass_rd", 32'(rd_ex), 4);
    check("pass_we", 32'(we_ex), 1);
    check("pass_a", data_a_ex, 32'hA000_0002);
    check("pass_b", data_b_ex, 32'hB000_0003);

    // load-use on rs
    set_id(1, 1, 0, 0, 5, 1, 1, 6'h23);
    step();
    set_id(1, 5, 9, 1, 6, 1, 0, 6'h20);
    #1 check("lu_stall", 32'(stall), 1);
    step();
    check("lu_bubble", 32'(valid_ex), 0);
    check("lu_cnt", 32'(bubble_cnt), 1);
    check("lu_stall_gone", 32'(stall), 0);
    step();
    check("lu_reload_rd", 32'(rd_ex), 6);

    // rt gating, then flush priority
    set_id(1, 1, 0, 0, 7, 1, 1, 6'h23);
    step();
    set_id(1, 1, 7, 0, 8, 1, 0, 6'h20);
    #1 check("rt_unused", 32'(stall), 0);
    use_rt_id = 1;
    #1 check("rt_used", 32'(stall), 1);
    flush = 1;
    #1 check("flush_nostall", 32'(stall), 0);
    step();
    flush = 0;
    check("flush_bubble", 32'(valid_ex), 0);
    check("flush_cnt", 32'(bubble_cnt), 1);

    // freeze holds EX and counter, even against cnt_clear
    set_id(1, 1, 0, 0, 7, 1, 1, 6'h23);
    step();
    set_id(1, 7, 0, 0, 8, 1, 0, 6'h20);
    freeze = 1; cnt_clear = 1;
    step();
    step();
    check("frz_rd", 32'(rd_ex), 7);
    check("frz_mr", 32'(mem_read_ex), 1);
    check("frz_cnt", 32'(bubble_cnt), 1);
    freeze = 0;
    // clear wins over the increment of this hazard
    step();
    cnt_clear = 0;
    check("clr_cnt", 32'(bubble_cnt), 0);
    check("clr_bubble", 32'(valid_ex), 0);

    // $0 destination never forwards or stalls
    set_id(1, 1, 0, 0, 0, 1, 1, 6'h23);
    step();
    check("z_we", 32'(we_ex), 0);
    set_id(1, 0, 0, 1, 9, 1, 0, 6'h20);
    #1 check("z_stall", 32'(stall), 0);
    step();

    // saturation: five hazards on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      set_id(1, 1, 0, 0, 5, 1, 1, 6'h23);
      step();
      set_id(1, 5, 0, 0, 9, 1, 0, 6'h20);
      step();
    end
    check("sat_cnt", 32'(bubble_cnt), 3);

    // reset in the middle of a stall
    set_id(1, 1, 0, 0, 5, 1, 1, 6'h23);
    step();
    set_id(1, 5, 0, 0, 9, 1, 0, 6'h20);
    #1 check("mid_stall_pre", 32'(stall), 1);
    rst_n = 0;
    #1 check("mid_stall_rst", 32'(stall), 0);
    check("mid_valid_rst", 32'(valid_ex), 0);
    check("mid_cnt_rst", 32'(bubble_cnt), 0);
    step();
    rst_n = 1;

    // mixed traffic against the model only
    for (int i = 0; i < 200; i++) begin
      random_id();
      flush = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      cnt_clear = ($urandom_range(0, 15) == 0);
      if (i % 3 == 0) begin
        mem_read_id = 1; we_id = 1; rd_id = NA'($urandom_range(1, 3));
      end else begin
        rs_id = NA'($urandom_range(0, 3)); rt_id = NA'($urandom_range(0, 3));
      end
      step();
    end
    set_nop(); flush = 0; freeze = 0; cnt_clear = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
